control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports as follows.
- clk  in  1  sole clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
REQ-002 The block SHALL have these fetch ports.
- imem_addr  out  8  instruction address; equals pc.
- imem_req  out  1  instruction fetch request.
- imem_ack  in  1  fetch complete; imem_data valid this cycle.
- imem_data  in  16  instruction word.
REQ-003 The block SHALL have these decoder ports.
- opcode  out  4  ir[15:12], continuously driven to the instruction decoder.
- ctrl_flags  in  8  decoded flags, with bit meanings:
  - [7] br, [6] imm, [5] jimm, [4] jreg
  - [3] link, [2] mw, [1] mr, [0] ld
REQ-004 The block SHALL have these datapath/memory ports.
- ir  out  16  instruction register.
- cond  in  1  branch condition.
- target_pc  in  8  jump/branch target.
- dmem_req  out  1  data access request.
- dmem_we  out  1  data write enable; valid with dmem_req.
- dmem_ack  in  1  data access complete.
- rf_we  out  1  register-file write strobe.
- instr_done  out  1  one-cycle retire pulse.

Function
REQ-005 The block SHALL implement states IDLE, FETCH, DECODE, EXEC, MEM and WB; reset state is IDLE, and IDLE->FETCH occurs unconditionally on the next cycle.
REQ-006 FETCH SHALL behave as follows.
- imem_req=1, imem_addr=pc.
- On imem_ack=1 in the same cycle: ir<=imem_data, state->DECODE.
- Otherwise: hold state, request and address.
REQ-007 imem_ack arriving in the first cycle of FETCH SHALL be accepted (zero-wait); ack outside FETCH SHALL be ignored, and likewise dmem_ack outside MEM.
REQ-008 DECODE SHALL be a single settle cycle for the decoder -> EXEC; ctrl_flags SHALL be sampled only in EXEC, MEM and WB.
REQ-009 EXEC SHALL go to MEM if mw|mr, else to WB.
REQ-010 MEM SHALL behave as follows.
- dmem_req=1 and dmem_we=mw, held until dmem_ack=1.
- On dmem_ack=1: state->WB.
- Zero-wait ack is accepted.
REQ-011 WB SHALL last exactly one cycle, then -> FETCH, with:
- rf_we = ~mw & ~br.
- instr_done=1.
- pc update per REQ-012.
REQ-012 pc SHALL update as follows.
- take = jreg | (jimm & ~br) | (br & cond).
- pc<=target_pc if take, else pc+1, modulo 256 (0xFF -> 0x00).
REQ-013 imem_req, dmem_req, dmem_we, rf_we and instr_done SHALL be 0 in every state other than the one named for them.
REQ-014 Zero-wait instruction latency SHALL be: 4 cycles FETCH-to-FETCH for non-memory ops, 5 for memory ops.

Reset
REQ-015 rst_n=0 SHALL immediately, without waiting for a clock edge, force:
- state=IDLE, pc=0x00, ir=0x0000;
- imem_req, dmem_req, dmem_we, rf_we and instr_done = 0.
REQ-016 Reset asserted mid-instruction, including during MEM with a request pending, SHALL abandon the instruction with no pc update and no rf_we.
REQ-017 After rst_n deasserts, the first imem_req SHALL appear on the second rising edge (IDLE then FETCH).

Configuration
REQ-018 The block SHALL support the macro SEQ_STEP_EN.
- Defined: adds input step (1 bit). WB->FETCH is replaced by WB->IDLE, and IDLE->FETCH occurs only on a cycle with step=1, so exactly one instruction runs per step pulse; the first fetch after reset also waits for step.
- Undefined: no step port; IDLE->FETCH is unconditional and WB->FETCH directly.

Verification
REQ-019 Reset, then imem_data=0x0123 with zero-wait ack at pc 0 -> ir=0x0123, opcode=0, rf_we and instr_done pulse in the 4th cycle after FETCH, pc=0x01.
REQ-020 Load: ctrl_flags=0x42, dmem_ack 3 cycles after MEM entry -> dmem_req high 4 cycles, dmem_we=0, then rf_we=1 and pc+1.
REQ-021 Branch: ctrl_flags=0xA0, target_pc=0x40 -> with cond=1, pc=0x40 and rf_we=0; with cond=0, pc=old+1.
REQ-022 Jump-register and wrap:
- ctrl_flags=0x18, target_pc=0x7F -> pc=0x7F and rf_we=1.
- Separately, a non-jump at pc=0xFF -> pc=0x00.
REQ-023 Assert rst_n=0 mid-cycle during MEM with dmem_req=1 -> dmem_req drops before the next clock edge; after release, pc=0x00 and the first imem_req appears on the 2nd edge.
REQ-024 With SEQ_STEP_EN defined, step pulses at cycles 10 and 30 -> exactly two instr_done pulses, and imem_req stays 0 between them while in IDLE.

Source files
------------

// File: rtl/control_sequencer.sv
// Multi-cycle fetch/decode/exec/mem/wb sequencer. Zero-wait instructions take 4 cycles, or 5 with a data access.
// Fetch and memory stalls last until the ack arrives. Define SEQ_STEP_EN to add a step input that runs one instruction per pulse.
module control_sequencer (
  input  logic        clk,
  input  logic        rst_n,
`ifdef SEQ_STEP_EN
  input  logic        step,
`endif
  output logic [7:0]  imem_addr,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  output logic [3:0]  opcode,
  input  logic [7:0]  ctrl_flags,
  output logic [15:0] ir,
  input  logic        cond,
  input  logic [7:0]  target_pc,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        rf_we,
  output logic        instr_done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic        imem_req_q, imem_req_d;
  logic        dmem_req_q, dmem_req_d;
  logic        dmem_we_q, dmem_we_d;
  logic        rf_we_q, rf_we_d;
  logic        instr_done_q, instr_done_d;

  logic br, jimm, jreg, mw, mr, take;
  logic unused_flags;

  assign br   = ctrl_flags[7];
  assign jimm = ctrl_flags[5];
  assign jreg = ctrl_flags[4];
  assign mw   = ctrl_flags[2];
  assign mr   = ctrl_flags[1];
  assign take = jreg | (jimm & ~br) | (br & cond);
  // imm, link and ld steer the datapath only; the sequencer has no use for them.
  assign unused_flags = ^{ctrl_flags[6], ctrl_flags[3], ctrl_flags[0]};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      IDLE: begin
`ifdef SEQ_STEP_EN
        if (step) state_d = FETCH;
`else
        state_d = FETCH;
`endif
      end
      FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_data;
          state_d = DECODE;
        end
      end
      DECODE: state_d = EXEC;
      EXEC:   state_d = (mw | mr) ? MEM : WB;
      MEM: begin
        if (dmem_ack) state_d = WB;
      end
      WB: begin
        pc_d = take ? target_pc : pc_q + 8'd1;
`ifdef SEQ_STEP_EN
        state_d = IDLE;
`else
        state_d = FETCH;
`endif
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    imem_req_d   = (state_d == FETCH);
    dmem_req_d   = (state_d == MEM);
    dmem_we_d    = (state_d == MEM) & mw;
    rf_we_d      = (state_d == WB) & ~mw & ~br;
    instr_done_d = (state_d == WB);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pc_q         <= 8'h00;
      ir_q         <= 16'h0000;
      imem_req_q   <= 1'b0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      rf_we_q      <= 1'b0;
      instr_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      imem_req_q   <= imem_req_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      rf_we_q      <= rf_we_d;
      instr_done_q <= instr_done_d;
    end
  end

  assign imem_addr  = pc_q;
  assign imem_req   = imem_req_q;
  assign ir         = ir_q;
  assign opcode     = ir_q[15:12];
  assign dmem_req   = dmem_req_q;
  assign dmem_we    = dmem_we_q;
  assign rf_we      = rf_we_q;
  assign instr_done = instr_done_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: reset, ALU/load/store/branch/jump, pc wrap, reset during MEM, step mode.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
`ifdef SEQ_STEP_EN
  logic        step;
`endif
  logic [7:0]  imem_addr;
  logic        imem_req;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic [3:0]  opcode;
  logic [7:0]  ctrl_flags;
  logic [15:0] ir;
  logic        cond;
  logic [7:0]  target_pc;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;
  logic        rf_we;
  logic        instr_done;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  control_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef SEQ_STEP_EN
    .step       (step),
`endif
    .imem_addr  (imem_addr),
    .imem_req   (imem_req),
    .imem_ack   (imem_ack),
    .imem_data  (imem_data),
    .opcode     (opcode),
    .ctrl_flags (ctrl_flags),
    .ir         (ir),
    .cond       (cond),
    .target_pc  (target_pc),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_ack   (dmem_ack),
    .rf_we      (rf_we),
    .instr_done (instr_done)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered at a falling edge while in FETCH; leaves at the falling edge of the next FETCH.
  task automatic do_instr(input string tag, input logic [15:0] data, input logic [7:0] flags,
                          input logic [7:0] tgt, input logic c, input int mwait,
                          input logic [7:0] exp_pc, input logic exp_rfwe);
    int n;
    chk($sformatf("%s fetch req", tag), 16'(imem_req), 16'(1));
    imem_ack = 1'b1; imem_data = data; ctrl_flags = flags; target_pc = tgt; cond = c;
    @(negedge clk);
    imem_data = 16'hDEAD;
    chk($sformatf("%s ir", tag), ir, data);
    chk($sformatf("%s opcode", tag), 16'(opcode), 16'(data[15:12]));
    chk($sformatf("%s decode req", tag), 16'(imem_req), 16'(0));
    @(negedge clk);
    imem_ack = 1'b0;
    chk($sformatf("%s ir held", tag), ir, data);
    chk($sformatf("%s exec rf_we", tag), 16'(rf_we), 16'(0));
    if (flags[2] | flags[1]) begin
      n = 0;
      for (int i = 0; i <= mwait; i++) begin
        @(negedge clk);
        if (dmem_req === 1'b1) n++;
        chk($sformatf("%s dmem_we", tag), 16'(dmem_we), 16'(flags[2]));
        if (i == mwait) dmem_ack = 1'b1;
      end
      @(negedge clk);
      dmem_ack = 1'b0;
      chk($sformatf("%s dmem_req cycles", tag), 16'(n), 16'(mwait + 1));
    end else begin
      @(negedge clk);
    end
    chk($sformatf("%s wb rf_we", tag), 16'(rf_we), 16'(exp_rfwe));
    chk($sformatf("%s wb done", tag), 16'(instr_done), 16'(1));
    chk($sformatf("%s wb dmem_req", tag), 16'(dmem_req), 16'(0));
    @(negedge clk);
    chk($sformatf("%s pc", tag), 16'(imem_addr), 16'(exp_pc));
    chk($sformatf("%s done low", tag), 16'(instr_done), 16'(0));
    chk($sformatf("%s next req", tag), 16'(imem_req), 16'(1));
  endtask

  initial begin
    int dones, reqs;
    rst_n = 1'b1; imem_ack = 1'b0; imem_data = 16'h0; ctrl_flags = 8'h0;
    cond = 1'b0; target_pc = 8'h0; dmem_ack = 1'b0;
`ifdef SEQ_STEP_EN
    step = 1'b0;
`endif
    #1 rst_n = 1'b0;
    #1;
    chk("rst pc", 16'(imem_addr), 16'(0));
    chk("rst ir", ir, 16'h0000);
    chk("rst imem_req", 16'(imem_req), 16'(0));
    chk("rst dmem_req", 16'(dmem_req), 16'(0));
    chk("rst dmem_we", 16'(dmem_we), 16'(0));
    chk("rst rf_we", 16'(rf_we), 16'(0));
    chk("rst done", 16'(instr_done), 16'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("release idle req", 16'(imem_req), 16'(0));

`ifdef SEQ_STEP_EN
    imem_ack = 1'b1;
    dones = 0; reqs = 0;
    for (int cyc = 1; cyc <= 50; cyc++) begin
      @(negedge clk);
      if (instr_done === 1'b1) dones++;
      if (imem_req === 1'b1) reqs++;
      if (cyc <= 10 || (cyc >= 16 && cyc <= 30))
        chk($sformatf("step idle req c%0d", cyc), 16'(imem_req), 16'(0));
      step = (cyc == 10 || cyc == 30);
    end
    imem_ack = 1'b0;
    chk("step done count", 16'(dones), 16'(2));
    chk("step fetch count", 16'(reqs), 16'(2));
    chk("step pc", 16'(imem_addr), 16'(2));
`else
    @(negedge clk);
    chk("first fetch addr", 16'(imem_addr), 16'(0));
    do_instr("alu",    16'h0123, 8'h00, 8'h00, 1'b0, 0, 8'h01, 1'b1);
    do_instr("load",   16'h8000, 8'h42, 8'h00, 1'b0, 3, 8'h02, 1'b1);
    do_instr("br t",   16'hC000, 8'hA0, 8'h40, 1'b1, 0, 8'h40, 1'b0);
    do_instr("br nt",  16'hC001, 8'hA0, 8'h10, 1'b0, 0, 8'h41, 1'b0);
    do_instr("store",  16'h9000, 8'h04, 8'h00, 1'b0, 0, 8'h42, 1'b0);
    do_instr("jreg",   16'hE000, 8'h18, 8'h7F, 1'b0, 0, 8'h7F, 1'b1);
    do_instr("jimm",   16'hD000, 8'h20, 8'hFF, 1'b0, 0, 8'hFF, 1'b1);
    do_instr("wrap",   16'h1111, 8'h00, 8'h33, 1'b1, 0, 8'h00, 1'b1);
    do_instr("alu2",   16'h2222, 8'h00, 8'h00, 1'b0, 0, 8'h01, 1'b1);

    // Load at pc 1 interrupted by reset while the data request is pending.
    imem_ack = 1'b1; imem_data = 16'h8888; ctrl_flags = 8'h42;
    @(negedge clk);
    imem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mem req before rst", 16'(dmem_req), 16'(1));
    rst_n = 1'b0;
    #1;
    chk("mid rst dmem_req", 16'(dmem_req), 16'(0));
    chk("mid rst pc", 16'(imem_addr), 16'(0));
    chk("mid rst ir", ir, 16'h0000);
    chk("mid rst rf_we", 16'(rf_we), 16'(0));
    chk("mid rst done", 16'(instr_done), 16'(0));
    @(negedge clk);
    rst_n = 1'b1; ctrl_flags = 8'h00;
    chk("re-release req", 16'(imem_req), 16'(0));
    @(negedge clk);
    chk("re-release fetch req", 16'(imem_req), 16'(1));
    chk("re-release pc", 16'(imem_addr), 16'(0));
    do_instr("post rst", 16'h3333, 8'h00, 8'h00, 1'b0, 0, 8'h01, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
